// File: rtl/cpu_pkg.sv
// Shared types and instruction field positions for the 8-bit CPU control unit.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_LDI   = 4'h6,
        OP_ADDI  = 4'h7,
        OP_BEQZ  = 4'h8,
        OP_JMP   = 4'h9,
        OP_ILL_A = 4'hA,
        OP_ILL_B = 4'hB,
        OP_ILL_C = 4'hC,
        OP_ILL_D = 4'hD,
        OP_ILL_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASSA = 3'd0,
        ALU_ADD   = 3'd1,
        ALU_SUB   = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_XOR   = 3'd5,
        ALU_PASSB = 3'd6
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Instruction field bit positions.
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 8;
    localparam int RS1_MSB  = 7;
    localparam int RS1_LSB  = 4;
    localparam int RS2_MSB  = 3;
    localparam int RS2_LSB  = 0;
    localparam int IMM8_MSB = 7;
    localparam int IMM8_LSB = 0;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus between the sequencer (master) and its ROM / register file / ALU (slave).
// Signalling is level-based, no handshake: the sequencer presents pc and the
// ROM answers with instr one cycle later; register-file controls are valid
// for the whole EXEC cycle and write_enable commits at the edge ending it.
interface cpu_sequencer_if
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pc;
    logic [15:0]     instr;
    logic            alu_zero;
    logic [3:0]      RA1;
    logic [3:0]      RA2;
    logic [3:0]      WA;
    logic            write_enable;
    alu_op_t         alu_op;
    logic [7:0]      imm;
    logic            imm_sel;

    modport master (
        output pc, RA1, RA2, WA, write_enable, alu_op, imm, imm_sel,
        input  instr, alu_zero
    );

    modport slave (
        input  pc, RA1, RA2, WA, write_enable, alu_op, imm, imm_sel,
        output instr, alu_zero
    );
endinterface

// File: rtl/cpu_sequencer_instr_decode.sv
// Purely combinational instruction decoder: latched ir -> datapath controls.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    output logic [3:0]  wa,
    output alu_op_t     alu_op,
    output logic [7:0]  imm,
    output logic        imm_sel,
    output logic        we_req,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_halt,
    output logic        is_illegal
);
    opcode_t    op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;

    assign op  = opcode_t'(ir[OPC_MSB:OPC_LSB]);
    assign rd  = ir[RD_MSB:RD_LSB];
    assign rs1 = ir[RS1_MSB:RS1_LSB];
    assign rs2 = ir[RS2_MSB:RS2_LSB];

    // Map opcode to register addresses, ALU function and control flags.
    always_comb begin
        ra1        = 4'd0;
        ra2        = 4'd0;
        wa         = 4'd0;
        alu_op     = ALU_PASSA;
        imm        = 8'd0;
        imm_sel    = 1'b0;
        we_req     = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                ra1    = rs1;
                ra2    = rs2;
                wa     = rd;
                we_req = (rd != 4'd0);
                case (op)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    OP_OR:   alu_op = ALU_OR;
                    default: alu_op = ALU_XOR;
                endcase
            end
            OP_LDI: begin
                wa      = rd;
                alu_op  = ALU_PASSB;
                imm     = ir[IMM8_MSB:IMM8_LSB];
                imm_sel = 1'b1;
                we_req  = (rd != 4'd0);
            end
            OP_ADDI: begin
                ra1     = rs1;
                wa      = rd;
                alu_op  = ALU_ADD;
                imm     = {4'd0, rs2};
                imm_sel = 1'b1;
                we_req  = (rd != 4'd0);
            end
            OP_BEQZ: begin
                // The tested register goes through the ALU unchanged so that
                // alu_zero reflects it directly.
                ra1       = rd;
                alu_op    = ALU_PASSA;
                is_branch = 1'b1;
            end
            OP_JMP:  is_jump = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// Three-cycle (FETCH, DECODE, EXEC) control unit: FSM, program counter,
// instruction register and sticky illegal-opcode flag.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    cpu_sequencer_if.master  bus,
    output logic             halted,
    output logic             illegal,
    output state_t           fsm_state
);
    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [15:0]     ir;
    logic            illegal_q;
    logic            exec;

    logic [3:0]      dec_ra1;
    logic [3:0]      dec_ra2;
    logic [3:0]      dec_wa;
    alu_op_t         dec_alu_op;
    logic [7:0]      dec_imm;
    logic            dec_imm_sel;
    logic            dec_we_req;
    logic            dec_is_branch;
    logic            dec_is_jump;
    logic            dec_is_halt;
    logic            dec_is_illegal;

    instr_decode u_decode (
        .ir         (ir),
        .ra1        (dec_ra1),
        .ra2        (dec_ra2),
        .wa         (dec_wa),
        .alu_op     (dec_alu_op),
        .imm        (dec_imm),
        .imm_sel    (dec_imm_sel),
        .we_req     (dec_we_req),
        .is_branch  (dec_is_branch),
        .is_jump    (dec_is_jump),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    assign exec = (state == ST_EXEC);

    // Next state and next pc; pc only moves at the end of EXEC.
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        case (state)
            ST_IDLE:   if (run) state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                if (dec_is_halt) begin
                    state_next = ST_HALT;
                end else begin
                    state_next = run ? ST_FETCH : ST_IDLE;
                    if (dec_is_jump || (dec_is_branch && bus.alu_zero))
                        pc_next = PC_W'(ir[IMM8_MSB:IMM8_LSB]);
                    else
                        pc_next = pc_q + PC_W'(1);
                end
            end
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath controls are live only in EXEC; reset suppresses a pending write.
    always_comb begin
        bus.RA1          = exec ? dec_ra1     : 4'd0;
        bus.RA2          = exec ? dec_ra2     : 4'd0;
        bus.WA           = exec ? dec_wa      : 4'd0;
        bus.alu_op       = exec ? dec_alu_op  : ALU_PASSA;
        bus.imm          = exec ? dec_imm     : 8'd0;
        bus.imm_sel      = exec && dec_imm_sel;
        bus.write_enable = exec && dec_we_req && !reset;
    end

    assign bus.pc    = pc_q;
    assign halted    = (state == ST_HALT);
    assign illegal   = illegal_q;
    assign fsm_state = state;

    // State, pc, instruction register and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc_q      <= '0;
            ir        <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            if (state == ST_DECODE)
                ir <= bus.instr;
            if (exec && dec_is_illegal)
                illegal_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: ROM, register file and ALU around the DUT, plus an
// instruction-level reference model of the CPU used for random programs.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   run;
    logic   halted;
    logic   illegal;
    state_t fsm_state;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure instruction spacing.
    always @(posedge clk) cyc <= cyc + 1;

    cpu_sequencer_if #(.PC_W(8)) bus ();

    cpu_sequencer #(.PC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .bus       (bus),
        .halted    (halted),
        .illegal   (illegal),
        .fsm_state (fsm_state)
    );

    // Synchronous instruction ROM.
    logic [15:0] rom [256];
    always @(posedge clk) bus.instr <= rom[bus.pc];

    // Register file with r0 reading as zero.
    logic [7:0] rf [16];
    logic       rf_clear;
    logic [7:0] rd1, rd2, alu_b, alu_y;
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (bus.write_enable && bus.WA != 4'd0) begin
            rf[bus.WA] <= alu_y;
        end
    end

    // ALU fed by the DUT's controls.
    always_comb begin
        rd1   = (bus.RA1 == 4'd0) ? 8'h00 : rf[bus.RA1];
        rd2   = (bus.RA2 == 4'd0) ? 8'h00 : rf[bus.RA2];
        alu_b = bus.imm_sel ? bus.imm : rd2;
        case (bus.alu_op)
            ALU_PASSA: alu_y = rd1;
            ALU_ADD:   alu_y = rd1 + alu_b;
            ALU_SUB:   alu_y = rd1 - alu_b;
            ALU_AND:   alu_y = rd1 & alu_b;
            ALU_OR:    alu_y = rd1 | alu_b;
            ALU_XOR:   alu_y = rd1 ^ alu_b;
            ALU_PASSB: alu_y = alu_b;
            default:   alu_y = 8'h00;
        endcase
    end
    assign bus.alu_zero = (alu_y == 8'h00);

    // Instruction-level reference model.
    logic [7:0] m_reg [16];
    logic [7:0] m_pc;
    logic       m_ill;
    logic       exp_we;
    logic [3:0] exp_wa;
    logic [7:0] exp_wdata;
    state_t     exp_state;

    task automatic model_step(input logic [15:0] ins);
        logic [3:0] op, rd, rs1, rs2;
        logic [7:0] a, b, res, next_pc;
        logic       wr;
        op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
        a = m_reg[rs1]; b = m_reg[rs2]; res = 8'h00; wr = 1'b0;
        exp_we = 1'b0; exp_wa = 4'd0; exp_wdata = 8'h00;
        exp_state = ST_FETCH;
        next_pc = m_pc + 8'd1;
        case (op)
            4'h1: begin res = a + b; wr = 1'b1; end
            4'h2: begin res = a - b; wr = 1'b1; end
            4'h3: begin res = a & b; wr = 1'b1; end
            4'h4: begin res = a | b; wr = 1'b1; end
            4'h5: begin res = a ^ b; wr = 1'b1; end
            4'h6: begin res = ins[7:0]; wr = 1'b1; end
            4'h7: begin res = a + {4'h0, rs2}; wr = 1'b1; end
            4'h8: if (m_reg[rd] == 8'h00) next_pc = ins[7:0];
            4'h9: next_pc = ins[7:0];
            4'hF: begin next_pc = m_pc; exp_state = ST_HALT; end
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: m_ill = 1'b1;
            default: ;
        endcase
        if (wr && rd != 4'd0) begin
            exp_we = 1'b1; exp_wa = rd; exp_wdata = res; m_reg[rd] = res;
        end
        m_pc = next_pc;
    endtask

    // Observations collected across one FETCH/DECODE/EXEC sequence.
    int         obs_we_n;
    logic       obs_we_exec;
    logic       obs_side_nz;
    logic [3:0] obs_wa;
    logic [7:0] obs_wdata;
    alu_op_t    obs_alu_op;
    logic [7:0] obs_imm;
    logic       obs_imm_sel;
    int         obs_exec_cyc;
    logic [7:0] obs_pc_fetch;
    logic [7:0] obs_pc_next;
    state_t     obs_state_next;
    logic       obs_illegal;
    logic       obs_halted;

    function automatic logic side_nz();
        return (bus.RA1 != 4'd0) || (bus.RA2 != 4'd0) || (bus.WA != 4'd0) ||
               (bus.alu_op != ALU_PASSA) || (bus.imm != 8'h00) || bus.imm_sel;
    endfunction

    // Called just after the edge entering FETCH; returns just after the edge
    // following EXEC.
    task automatic step_instr();
        obs_we_n = 0; obs_side_nz = 1'b0;
        obs_pc_fetch = bus.pc;
        if (bus.write_enable) obs_we_n++;
        if (side_nz()) obs_side_nz = 1'b1;
        @(posedge clk); #1;
        if (bus.write_enable) obs_we_n++;
        if (side_nz()) obs_side_nz = 1'b1;
        @(posedge clk); #1;
        obs_we_exec = bus.write_enable;
        if (bus.write_enable) obs_we_n++;
        obs_wa = bus.WA; obs_wdata = alu_y; obs_alu_op = bus.alu_op;
        obs_imm = bus.imm; obs_imm_sel = bus.imm_sel; obs_exec_cyc = cyc;
        @(posedge clk); #1;
        obs_pc_next = bus.pc; obs_state_next = fsm_state;
        obs_illegal = illegal; obs_halted = halted;
    endtask

    task automatic do_reset();
        reset = 1'b1; rf_clear = 1'b1; run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; rf_clear = 1'b0;
        m_pc = 8'h00; m_ill = 1'b0;
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic start_run();
        run = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clear_rom();
        do_reset();
        n_checks++; if (fsm_state !== ST_IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
        n_checks++; if (bus.pc !== 8'h00) begin n_errors++; $display("FAIL reset_pc: got %0h expected 0", bus.pc); end
        n_checks++; if ({halted, illegal, bus.write_enable} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {halted, illegal, bus.write_enable}); end
        n_checks++; if (side_nz() !== 1'b0) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 0", side_nz()); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (fsm_state !== ST_IDLE || bus.pc !== 8'h00) begin n_errors++; $display("FAIL idle_hold: got state %0d pc %0h expected state 0 pc 0", fsm_state, bus.pc); end
    endtask

    task automatic test_ldi_add_sub();
        int c_add;
        clear_rom();
        rom[0] = 16'h6105; rom[1] = 16'h1211; rom[2] = 16'h2321; rom[3] = 16'hF000;
        do_reset();
        start_run();
        n_checks++; if (fsm_state !== ST_FETCH) begin n_errors++; $display("FAIL first_fetch: got %0d expected %0d", fsm_state, ST_FETCH); end
        step_instr();
        n_checks++; if (obs_we_n !== 1 || obs_we_exec !== 1'b1) begin n_errors++; $display("FAIL ldi_we: got count %0d exec %b expected 1 1", obs_we_n, obs_we_exec); end
        n_checks++; if (obs_wa !== 4'd1 || obs_imm !== 8'h05 || obs_imm_sel !== 1'b1) begin n_errors++; $display("FAIL ldi_ctrl: got wa %0d imm %0h sel %b expected 1 05 1", obs_wa, obs_imm, obs_imm_sel); end
        n_checks++; if (obs_pc_next !== 8'h01 || obs_state_next !== ST_FETCH) begin n_errors++; $display("FAIL ldi_pc: got pc %0h state %0d expected 1 %0d", obs_pc_next, obs_state_next, ST_FETCH); end
        step_instr();
        c_add = obs_exec_cyc;
        n_checks++; if (obs_we_n !== 1 || obs_wa !== 4'd2 || obs_alu_op !== ALU_ADD || obs_wdata !== 8'h0A) begin n_errors++; $display("FAIL add: got we %0d wa %0d op %0d data %0h expected 1 2 1 0a", obs_we_n, obs_wa, obs_alu_op, obs_wdata); end
        step_instr();
        n_checks++; if (obs_we_n !== 1 || obs_wa !== 4'd3 || obs_alu_op !== ALU_SUB || obs_wdata !== 8'h05) begin n_errors++; $display("FAIL sub: got we %0d wa %0d op %0d data %0h expected 1 3 2 05", obs_we_n, obs_wa, obs_alu_op, obs_wdata); end
        n_checks++; if (obs_exec_cyc - c_add !== 3) begin n_errors++; $display("FAIL add_sub_spacing: got %0d expected 3", obs_exec_cyc - c_add); end
    endtask

    task automatic test_r0_beqz();
        clear_rom();
        rom[0] = 16'h607F; rom[1] = 16'h8020;
        rom[8'h20] = 16'h6301; rom[8'h21] = 16'h8340; rom[8'h22] = 16'hF000;
        do_reset();
        start_run();
        step_instr();
        n_checks++; if (obs_we_n !== 0) begin n_errors++; $display("FAIL ldi_r0_we: got %0d expected 0", obs_we_n); end
        step_instr();
        n_checks++; if (obs_pc_next !== 8'h20) begin n_errors++; $display("FAIL beqz_r0_taken: got %0h expected 20", obs_pc_next); end
        step_instr();
        step_instr();
        n_checks++; if (obs_pc_next !== 8'h22) begin n_errors++; $display("FAIL beqz_nonzero: got %0h expected 22", obs_pc_next); end
    endtask

    task automatic test_wrap_illegal();
        clear_rom();
        rom[0] = 16'h90FE; rom[8'hFE] = 16'hB123; rom[8'hFF] = 16'h0000;
        do_reset();
        start_run();
        step_instr();
        n_checks++; if (obs_pc_next !== 8'hFE || obs_illegal !== 1'b0) begin n_errors++; $display("FAIL jmp: got pc %0h ill %b expected fe 0", obs_pc_next, obs_illegal); end
        step_instr();
        n_checks++; if (obs_we_n !== 0 || obs_illegal !== 1'b1 || obs_pc_next !== 8'hFF) begin n_errors++; $display("FAIL illegal_op: got we %0d ill %b pc %0h expected 0 1 ff", obs_we_n, obs_illegal, obs_pc_next); end
        step_instr();
        n_checks++; if (obs_pc_next !== 8'h00 || obs_illegal !== 1'b1) begin n_errors++; $display("FAIL pc_wrap: got pc %0h ill %b expected 00 1", obs_pc_next, obs_illegal); end
        step_instr();
        n_checks++; if (obs_illegal !== 1'b1) begin n_errors++; $display("FAIL illegal_sticky: got %b expected 1", obs_illegal); end
    endtask

    task automatic test_pause();
        int idle_we;
        clear_rom();
        rom[0] = 16'h6111; rom[1] = 16'h6222; rom[2] = 16'hF000;
        do_reset();
        start_run();
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.write_enable !== 1'b1 || bus.WA !== 4'd1) begin n_errors++; $display("FAIL pause_exec: got we %b wa %0d expected 1 1", bus.write_enable, bus.WA); end
        @(posedge clk); #1;
        n_checks++; if (fsm_state !== ST_IDLE || bus.pc !== 8'h01) begin n_errors++; $display("FAIL pause_idle: got state %0d pc %0h expected %0d 01", fsm_state, bus.pc, ST_IDLE); end
        idle_we = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.write_enable) idle_we++;
        end
        n_checks++; if (fsm_state !== ST_IDLE || bus.pc !== 8'h01 || idle_we !== 0) begin n_errors++; $display("FAIL pause_hold: got state %0d pc %0h we %0d expected %0d 01 0", fsm_state, bus.pc, idle_we, ST_IDLE); end
        start_run();
        n_checks++; if (fsm_state !== ST_FETCH || bus.pc !== 8'h01) begin n_errors++; $display("FAIL resume_fetch: got state %0d pc %0h expected %0d 01", fsm_state, bus.pc, ST_FETCH); end
        step_instr();
        n_checks++; if (obs_wa !== 4'd2 || obs_wdata !== 8'h22 || obs_pc_next !== 8'h02) begin n_errors++; $display("FAIL resume_instr: got wa %0d data %0h pc %0h expected 2 22 02", obs_wa, obs_wdata, obs_pc_next); end
    endtask

    task automatic test_halt();
        int halt_we;
        clear_rom();
        rom[0] = 16'h6105; rom[1] = 16'hF000; rom[2] = 16'h6207;
        do_reset();
        start_run();
        step_instr();
        step_instr();
        n_checks++; if (obs_state_next !== ST_HALT || obs_halted !== 1'b1 || obs_pc_next !== 8'h01) begin n_errors++; $display("FAIL halt_enter: got state %0d halted %b pc %0h expected %0d 1 01", obs_state_next, obs_halted, obs_pc_next, ST_HALT); end
        halt_we = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.write_enable) halt_we++;
        end
        n_checks++; if (halted !== 1'b1 || bus.pc !== 8'h01 || halt_we !== 0 || fsm_state !== ST_HALT) begin n_errors++; $display("FAIL halt_hold: got halted %b pc %0h we %0d state %0d expected 1 01 0 %0d", halted, bus.pc, halt_we, fsm_state, ST_HALT); end
    endtask

    task automatic test_reset_in_exec();
        clear_rom();
        rom[0] = 16'h6105; rom[1] = 16'h1211;
        do_reset();
        start_run();
        step_instr();
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (fsm_state !== ST_EXEC) begin n_errors++; $display("FAIL reach_exec: got %0d expected %0d", fsm_state, ST_EXEC); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.write_enable !== 1'b0) begin n_errors++; $display("FAIL reset_exec_we: got %b expected 0", bus.write_enable); end
        @(posedge clk); #1;
        reset = 1'b0;
        run = 1'b0;
        n_checks++; if (fsm_state !== ST_IDLE || bus.pc !== 8'h00 || rf[2] !== 8'h00) begin n_errors++; $display("FAIL reset_exec_abort: got state %0d pc %0h r2 %0h expected %0d 00 00", fsm_state, bus.pc, rf[2], ST_IDLE); end
    endtask

    task automatic test_random_program();
        int prev_cyc;
        for (int i = 0; i < 256; i++) begin
            int op;
            op = $urandom_range(0, 14);
            rom[i] = {4'(op), 12'($urandom)};
        end
        do_reset();
        start_run();
        prev_cyc = 0;
        for (int n = 0; n < 60; n++) begin
            n_checks++; if (bus.pc !== m_pc) begin n_errors++; $display("FAIL rnd_fetch_pc[%0d]: got %0h expected %0h", n, bus.pc, m_pc); end
            model_step(rom[m_pc]);
            step_instr();
            n_checks++; if (obs_we_n !== int'(exp_we)) begin n_errors++; $display("FAIL rnd_we[%0d]: got %0d expected %0d", n, obs_we_n, exp_we); end
            if (exp_we) begin
                n_checks++; if (obs_wa !== exp_wa || obs_wdata !== exp_wdata) begin n_errors++; $display("FAIL rnd_write[%0d]: got r%0d=%0h expected r%0d=%0h", n, obs_wa, obs_wdata, exp_wa, exp_wdata); end
            end
            n_checks++; if (obs_pc_next !== m_pc || obs_state_next !== exp_state) begin n_errors++; $display("FAIL rnd_next[%0d]: got pc %0h state %0d expected %0h %0d", n, obs_pc_next, obs_state_next, m_pc, exp_state); end
            n_checks++; if (obs_side_nz !== 1'b0 || obs_illegal !== m_ill) begin n_errors++; $display("FAIL rnd_misc[%0d]: got ctrl %b ill %b expected 0 %b", n, obs_side_nz, obs_illegal, m_ill); end
            if (n > 0) begin
                n_checks++; if (obs_exec_cyc - prev_cyc !== 3) begin n_errors++; $display("FAIL rnd_spacing[%0d]: got %0d expected 3", n, obs_exec_cyc - prev_cyc); end
            end
            prev_cyc = obs_exec_cyc;
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; rf_clear = 1'b1;
        test_reset();
        test_ldi_add_sub();
        test_r0_beqz();
        test_wrap_illegal();
        test_pause();
        test_halt();
        test_reset_in_exec();
        test_random_program();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the 8-bit CPU. It steps a program counter, latches 16-bit instructions from a synchronous instruction ROM, and sequences the 16×8 register file (two read ports, one write port, r0 hardwired to zero, r15 wired to the CPU output) and the ALU. Each instruction takes exactly three cycles: FETCH, DECODE, EXEC.

## Interface
Parameters:
- PC_W, 8, program counter width; ROM depth is 2**PC_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; start or continue execution, sampled in IDLE and at the end of EXEC.
- instr  in  16  ROM read data; valid one cycle after pc is presented.
- alu_zero  in  1  ALU result == 0, combinational from the current ALU inputs.
- pc  out  PC_W  ROM address.
- RA1, RA2, WA  out  4  register file read and write addresses.
- write_enable  out  1  register file write strobe.
- alu_op  out  3  ALU function select.
- imm  out  8  immediate for ALU operand B.
- imm_sel  out  1  selects imm instead of RD2 as ALU operand B.
- halted  out  1  high in HALT.
- illegal  out  1  sticky flag; high once an undefined opcode has executed.

## Operation
- Instruction fields: [15:12] opcode, [11:8] rd (rs for BEQZ), [7:4] rs1, [3:0] rs2 or imm4, [7:0] imm8 or target.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <= rs1 op rs2.
  - 6 LDI: rd <= imm8 (RA1=0, alu_op PASSB, imm_sel=1).
  - 7 ADDI: rd <= rs1 + zero-extended imm4.
  - 8 BEQZ: RA1=rd, alu_op PASSA; if alu_zero then pc <= imm8.
  - 9 JMP: pc <= imm8.
  - F HALT.
  - A–E: executed as NOP; set illegal.
- ALU codes: PASSA=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, PASSB=6. Arithmetic is mod 256; no carry or overflow.
- States:
  - IDLE: wait; run=1 -> FETCH.
  - FETCH: present pc -> DECODE.
  - DECODE: latch instr into ir -> EXEC.
  - EXEC: drive the decoded controls from ir. Next state: HALT if opcode F; else FETCH if run=1; else IDLE.
  - HALT: absorbing; only reset leaves it.
- write_enable is high only in EXEC, for one cycle, for ALU/LDI/ADDI opcodes with rd ≠ 0. A write to r0 is suppressed.
- pc updates only at the end of EXEC: the branch/jump target, else pc+1 with wrap FF -> 00. HALT does not advance pc.
- RA1, RA2, WA, alu_op, imm and imm_sel are 0 outside EXEC.
- Pausing (run=0) takes effect only at an instruction boundary; an in-flight instruction always completes.

## Timing
- Reset values: state IDLE, pc=0, ir=0, all outputs 0 (including halted and illegal).
- Reset mid-instruction aborts it: no write that cycle, pc returns to 0.
- Latency: instruction at pc issues FETCH in cycle n, is latched at the end of n+1, and writes the register file at the clock edge ending n+2. The next FETCH is in n+3.
- A read-after-write between consecutive instructions needs no stall: the write completes two cycles before the next EXEC.
- The branch decision uses alu_zero sampled in EXEC. BEQZ on r0 is always taken.
- With run held high, throughput is one instruction per 3 cycles.

## Structure
- cpu_pkg holds:
  - opcode_t enum.
  - alu_op_t enum.
  - state_t enum.
  - instruction field bit positions (localparams).
- Sub-module instr_decode is purely combinational: ir -> {RA1, RA2, WA, alu_op, imm, imm_sel, we_req, is_branch, is_jump, is_halt, is_illegal}. cpu_sequencer holds only the FSM, pc, ir and the illegal flag.

## Test plan
- Reset, then run=1 with ROM[0]=LDI r1,0x05 -> write_enable in cycle 2 only, WA=1, imm=0x05, imm_sel=1; pc=1 at cycle 3.
- ADD r2,r1,r1 then SUB r3,r2,r1 (from r1=5) -> WA=2 then WA=3, alu_op 1 then 2, one write each, 3 cycles apart; r3=5.
- LDI r0,0x7F -> write_enable stays 0 for the whole instruction. BEQZ r0,0x20 -> pc=0x20.
- pc=0xFF with NOP -> pc wraps to 0x00. Opcode 0xB -> NOP behaviour and illegal=1, held after later instructions.
- run dropped during DECODE -> EXEC still completes, FSM enters IDLE, pc holds; run=1 resumes at the next pc.
- HALT -> halted=1, pc frozen, no writes for 10+ cycles despite run=1. Reset asserted in EXEC of an ADD -> no write, pc=0, state IDLE.
